// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Optional single-cycle multiply: define MULDIV_FAST_MUL_EN.
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] acc;
  logic               sign_q;
  logic               sign_r;
  logic               is_div;

  logic               op_signed;
  logic [WIDTH-1:0]   src1_mag;
  logic [WIDTH-1:0]   src2_mag;

  always_comb begin
    op_signed = ~op[0];
    src1_mag  = (op_signed && src1[WIDTH-1]) ? -src1 : src1;
    src2_mag  = (op_signed && src2[WIDTH-1]) ? -src2 : src2;
  end

  // Restoring division: acc holds {remainder, dividend/quotient}, quotient
  // bits shift in from the right as dividend bits shift out the top.
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_borrow;
  logic [2*WIDTH-1:0] div_next;

  always_comb begin
    div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_borrow = div_shift < {1'b0, b_mag};
    div_diff   = div_shift[WIDTH-1:0] - b_mag;
    div_next   = div_borrow ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                            : {div_diff, acc[WIDTH-2:0], 1'b1};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  logic [2*WIDTH-1:0] fast_res;

  always_comb begin
    fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
    fast_res  = sign_q ? -fast_prod : fast_prod;
  end
`else
  // Shift-add: acc starts as {0, multiplier}; each step adds the multiplicand
  // into the upper half when the current multiplier LSB is set.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? a_mag : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};
  end
`endif

  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   q_res;
  logic [WIDTH-1:0]   r_res;

  always_comb begin
    mul_res = sign_q ? -acc : acc;
    q_res   = (b_mag == '0) ? '1 : (sign_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
    r_res   = sign_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_mag    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      is_div   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              div_zero <= 1'b0;
              sign_q   <= op_signed & (src1[WIDTH-1] ^ src2[WIDTH-1]);
              sign_r   <= op_signed & src1[WIDTH-1];
              a_mag    <= src1_mag;
              b_mag    <= src2_mag;
              cnt      <= CNT_W'(WIDTH);
              case (op)
                3'b000, 3'b001: begin
                  state  <= MUL;
                  busy   <= 1'b1;
                  is_div <= 1'b0;
                  acc    <= {{WIDTH{1'b0}}, src2_mag};
                end
                3'b010, 3'b011: begin
                  state  <= DIV;
                  busy   <= 1'b1;
                  is_div <= 1'b1;
                  acc    <= {{WIDTH{1'b0}}, src1_mag};
                end
                3'b100:  hi <= src1;
                3'b101:  lo <= src1;
                default: ;
              endcase
            end
          end
          MUL: begin
`ifdef MULDIV_FAST_MUL_EN
            {hi, lo} <= fast_res;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= IDLE;
`else
            acc <= mul_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
`endif
          end
          DIV: begin
            acc <= div_next;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) state <= FIX;
          end
          FIX: begin
            if (is_div) begin
              lo       <= q_res;
              hi       <= r_res;
              div_zero <= (b_mag == '0);
            end else begin
              {hi, lo} <= mul_res;
            end
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized self-checking bench for muldiv_unit against a 64-bit arithmetic model.
module tb_muldiv_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] src1;
  logic [W-1:0] src2;
  logic         cancel;
  logic         busy;
  logic         done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;
  logic         div_zero;

  muldiv_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src1(src1), .src2(src2),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  logic         m_dz = 1'b0;
  bit           fast;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted operation on HI/LO/div_zero.
  task automatic model_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    m_dz = 1'b0;
    case (o)
      3'd0: begin p = sa * sb; {m_hi, m_lo} = p; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; end
      3'd2, 3'd3: begin
        if (b == '0) begin
          m_lo = '1; m_hi = a; m_dz = 1'b1;
        end else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb;
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end else begin
          sq = {32'b0, a} / {32'b0, b}; sr = {32'b0, a} % {32'b0, b};
          m_lo = sq[31:0]; m_hi = sr[31:0];
        end
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
  endtask

  task automatic mt_op(input logic [2:0] o, input logic [W-1:0] a);
    model_op(o, a, '0);
    op = o; src1 = a; src2 = $urandom; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom;
    check("mt_busy", busy, 0);
    check("mt_done", done, 0);
    check("mt_hi", hi, m_hi);
    check("mt_lo", lo, m_lo);
    check("mt_dz", div_zero, m_dz);
  endtask

  // inj: cycle index at which a stray start is pulsed while busy (-1 = none).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int inj, input bit chk_pulse);
    logic [W-1:0] ph, pl;
    int n, held_bad, lat;
    ph = m_hi; pl = m_lo;
    model_op(o, a, b);
    lat = (fast && o < 3'd2) ? 1 : W + 1;
    op = o; src1 = a; src2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; src1 = $urandom; src2 = $urandom; op = 3'($urandom);
    check("busy_start", busy, 1);
    check("dz_clear", div_zero, 0);
    n = 0; held_bad = 0;
    while (!done && n < 100) begin
      if (hi !== ph || lo !== pl) held_bad++;
      if (n == inj) begin
        start = 1'b1; op = 3'd3; src1 = $urandom; src2 = $urandom | 1;
      end
      @(posedge clk); #1;
      start = 1'b0; n++;
    end
    check("latency", n, lat);
    check("busy_done", busy, 0);
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("div_zero", div_zero, m_dz);
    check("hold", held_bad, 0);
    if (chk_pulse) begin
      @(posedge clk); #1;
      check("done_pulse", done, 0);
      check("idle_busy", busy, 0);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dcnt;
`ifdef MULDIV_FAST_MUL_EN
    fast = 1'b1;
`else
    fast = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; cancel = 1'b0; op = '0; src1 = '0; src2 = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dz", div_zero, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    mt_op(3'd4, 32'h1234);
    mt_op(3'd5, 32'h5678);

    // DIV cancelled after E10: nothing architectural changes
    m_dz = 1'b0;
    op = 3'd2; src1 = 32'd1000; src2 = 32'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1; cancel = 1'b0;
    check("cancel_busy", busy, 0);
    check("cancel_done", done, 0);
    check("cancel_hi", hi, 32'h1234);
    check("cancel_lo", lo, 32'h5678);
    dcnt = 0;
    repeat (40) begin @(posedge clk); #1; if (done || busy) dcnt++; end
    check("cancel_quiet", dcnt, 0);

    // cancel beats start in IDLE
    op = 3'd4; src1 = 32'hDEAD; start = 1'b1; cancel = 1'b1;
    @(posedge clk); #1; start = 1'b0; cancel = 1'b0;
    check("cancel_start_hi", hi, m_hi);
    check("cancel_start_busy", busy, 0);

    run_op(3'd0, 32'hFFFF_FFFD, 32'd7, -1, 1'b1);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFEB);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0);
    check("multu_lo_const", lo, 32'h0000_0001);
    run_op(3'd2, -32'sd7, 32'd2, -1, 1'b0);
    run_op(3'd3, 32'd100, 32'd7, -1, 1'b0);
    check("divu_lo_const", lo, 32'd14);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1, 1'b1);
    check("ovf_lo_const", lo, 32'h8000_0000);
    run_op(3'd3, 32'd5, 32'd0, -1, 1'b1);
    check("dz_set", div_zero, 1);
    run_op(3'd0, 32'h0001_2345, 32'hFFFF_0003, 5, 1'b1);
    run_op(3'd2, 32'hFFFF_FF00, 32'd0, -1, 1'b0);
    mt_op(3'd6, 32'hCAFE);

    for (int i = 0; i < 60; i++) begin
      logic [2:0] o;
      o = 3'($urandom_range(0, 7));
      if (o < 3'd4) run_op(o, pick(), pick(), ($urandom_range(0, 3) == 0) ? 3 : -1, 1'($urandom));
      else mt_op(o, $urandom);
    end

    // asynchronous reset during a divide
    mt_op(3'd4, 32'hA5A5_0001);
    op = 3'd3; src1 = 32'd77; src2 = 32'd5; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_dz", div_zero, 0);
    check("arst_hi", hi, 0);
    check("arst_lo", lo, 0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(3'd3, 32'd100, 32'd7, -1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
